// File: rtl/tap_tempo_pkg.sv
// Shared constants and divider state encoding for the tap-tempo datapath.
package tap_tempo_pkg;

  localparam int PER_WIDTH = 24;
  localparam int BPM_WIDTH = 8;
  localparam int DIVIDEND  = 60000;
  localparam int BPM_MAX   = 250;
  localparam int QW        = $clog2(DIVIDEND + 1);

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    DONE
  } div_state_e;

endpackage

// File: rtl/seq_udiv.sv
// Generic unsigned restoring divider: one quotient bit per clock, DVD_W steps,
// done_o high for the single cycle after the last step.
module seq_udiv
  import tap_tempo_pkg::*;
#(
  parameter int DVD_W = 16,
  parameter int DVS_W = 24
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [DVD_W-1:0] dividend_i,
  input  logic [DVS_W-1:0] divisor_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [DVD_W-1:0] quotient_o
);

  localparam int CW = (DVD_W > 1) ? $clog2(DVD_W) : 1;

  div_state_e       state_q, state_d;
  logic [DVD_W-1:0] dvd_q, dvd_d;
  logic [DVS_W-1:0] dvs_q, dvs_d;
  logic [DVS_W-1:0] rem_q, rem_d;
  logic [DVD_W-1:0] quo_q, quo_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Partial remainder after shifting in the next dividend bit; it is always
  // below 2*divisor, so the stored remainder never needs the extra top bit.
  logic [DVS_W:0]   rem_shift;
  logic [DVS_W-1:0] rem_sub;
  logic             qbit;

  assign rem_shift = {rem_q, dvd_q[DVD_W-1]};
  assign qbit      = (rem_shift >= {1'b0, dvs_q});
  assign rem_sub   = rem_shift[DVS_W-1:0] - dvs_q;

  // NOTE: every next-state signal takes its hold value first so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          dvd_d   = dividend_i;
          dvs_d   = divisor_i;
          rem_d   = '0;
          quo_d   = '0;
          cnt_d   = CW'(DVD_W - 1);
          state_d = DIV;
        end
      end
      DIV: begin
        rem_d = qbit ? rem_sub : rem_shift[DVS_W-1:0];
        dvd_d = {dvd_q[DVD_W-2:0], 1'b0};
        quo_d = {quo_q[DVD_W-2:0], qbit};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == '0) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state updates use non-blocking assignments so every register samples
  // pre-edge values; the datapath is cleared on reset so an aborted division
  // leaves nothing behind.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
    end
  end

  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == DONE);
  assign quotient_o = quo_q;

endmodule

// File: rtl/per2bpm.sv
// Tap period (ms) to tempo (BPM): DIVIDEND / period through a sequential
// divider, saturated to BPM_MAX and held until the next result.
module per2bpm #(
  parameter int PER_WIDTH = tap_tempo_pkg::PER_WIDTH,
  parameter int BPM_WIDTH = tap_tempo_pkg::BPM_WIDTH,
  parameter int DIVIDEND  = tap_tempo_pkg::DIVIDEND,
  parameter int BPM_MAX   = tap_tempo_pkg::BPM_MAX,
  parameter int QW        = $clog2(DIVIDEND + 1)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [PER_WIDTH-1:0] btn_per_i,
  input  logic                 btn_per_valid,
  output logic [BPM_WIDTH-1:0] bpm_o,
  output logic                 bpm_valid
);

  logic                 div_busy;
  logic                 div_done;
  logic [QW-1:0]        quotient;
  logic [BPM_WIDTH-1:0] bpm_q, bpm_d;
  logic                 bpm_valid_q, bpm_valid_d;

  // Strobes arriving while a division is in flight are dropped, not queued.
  seq_udiv #(
    .DVD_W(QW),
    .DVS_W(PER_WIDTH)
  ) u_div (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .start_i    (btn_per_valid & ~div_busy),
    .dividend_i (QW'(DIVIDEND)),
    .divisor_i  (btn_per_i),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (quotient)
  );

  always_comb begin
    bpm_d       = bpm_q;
    bpm_valid_d = 1'b0;
    if (div_done) begin
      bpm_d       = (quotient > QW'(BPM_MAX)) ? BPM_WIDTH'(BPM_MAX)
                                              : quotient[BPM_WIDTH-1:0];
      bpm_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      bpm_q       <= '0;
      bpm_valid_q <= 1'b0;
    end else begin
      bpm_q       <= bpm_d;
      bpm_valid_q <= bpm_valid_d;
    end
  end

  assign bpm_o     = bpm_q;
  assign bpm_valid = bpm_valid_q;

endmodule

// File: tb/tb_per2bpm.sv
// Directed bench for per2bpm: latency, saturation, zero/overflow periods,
// strobe dropping and reset abort, with hand-computed expected tempos.
module tb_per2bpm;

  localparam int LAT = 17;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [23:0] btn_per_i = '0;
  logic        btn_per_valid = 1'b0;
  logic [7:0]  bpm_o;
  logic        bpm_valid;

  int asserts = 0;
  int failures = 0;
  int pulses_seen = 0;

  per2bpm dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .btn_per_i     (btn_per_i),
    .btn_per_valid (btn_per_valid),
    .bpm_o         (bpm_o),
    .bpm_valid     (bpm_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [23:0] per);
    btn_per_i     = per;
    btn_per_valid = 1'b1;
    step();
    btn_per_valid = 1'b0;
  endtask

  // Returns the edge count (1-based) at which bpm_valid rose, 0 on timeout.
  task automatic wait_valid(input int max, output int n);
    n = 0;
    for (int i = 1; i <= max; i++) begin
      step();
      if (bpm_valid === 1'b1) begin
        n = i;
        pulses_seen++;
        break;
      end
    end
  endtask

  task automatic run_div(input logic [23:0] per, input logic [7:0] exp, input string name);
    int n;
    strobe(per);
    wait_valid(40, n);
    asserts++;
    if (n !== LAT) begin
      failures++;
      $display("FAIL %s latency: got %0d edges, expected %0d", name, n, LAT);
    end
    asserts++;
    if (bpm_o !== exp) begin
      failures++;
      $display("FAIL %s value: got %0d, expected %0d", name, bpm_o, exp);
    end
    step();
    asserts++;
    if (bpm_valid !== 1'b0 || bpm_o !== exp) begin
      failures++;
      $display("FAIL %s hold: valid=%b bpm=%0d, expected valid=0 bpm=%0d",
               name, bpm_valid, bpm_o, exp);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    btn_per_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      asserts++;
      if (bpm_o !== 8'd0 || bpm_valid !== 1'b0) begin
        failures++;
        $display("FAIL reset cycle %0d: bpm=%0d valid=%b, expected 0/0", i, bpm_o, bpm_valid);
      end
    end
    rst_i = 1'b0;
    step();
    asserts++;
    if (bpm_o !== 8'd0 || bpm_valid !== 1'b0) begin
      failures++;
      $display("FAIL post_reset: bpm=%0d valid=%b, expected 0/0", bpm_o, bpm_valid);
    end
  endtask

  task automatic test_nominal();
    run_div(24'd1000, 8'd60,  "per1000");
    run_div(24'd500,  8'd120, "per500");
    run_div(24'd750,  8'd80,  "per750");
  endtask

  task automatic test_saturation();
    run_div(24'd240, 8'd250, "per240_exact");
    run_div(24'd200, 8'd250, "per200_sat");
    run_div(24'd0,   8'd250, "per0");
  endtask

  task automatic test_slow();
    run_div(24'd60001,    8'd0, "per60001");
    run_div(24'd1000,     8'd60, "per1000_again");
    run_div(24'hFFFFFF,   8'd0, "perFFFFFF");
  endtask

  // Second strobe during the division must be dropped.
  task automatic test_back_to_back();
    int pulses = 0;
    int first_edge = 0;
    logic [7:0] first_val = '0;
    strobe(24'd1000);
    for (int i = 1; i <= 4; i++) step();
    strobe(24'd500);
    for (int e = 6; e <= 45; e++) begin
      step();
      if (bpm_valid === 1'b1) begin
        pulses++;
        pulses_seen++;
        if (pulses == 1) begin
          first_edge = e;
          first_val  = bpm_o;
        end
      end
    end
    asserts++;
    if (pulses !== 1) begin
      failures++;
      $display("FAIL b2b pulses: got %0d, expected 1", pulses);
    end
    asserts++;
    if (first_edge !== LAT || first_val !== 8'd60) begin
      failures++;
      $display("FAIL b2b result: edge=%0d bpm=%0d, expected edge=%0d bpm=60",
               first_edge, first_val, LAT);
    end
  endtask

  task automatic test_reset_abort();
    int n;
    strobe(24'd1000);
    for (int i = 1; i <= 7; i++) step();
    rst_i = 1'b1;
    step();
    asserts++;
    if (bpm_o !== 8'd0 || bpm_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort reset: bpm=%0d valid=%b, expected 0/0", bpm_o, bpm_valid);
    end
    rst_i = 1'b0;
    wait_valid(30, n);
    asserts++;
    if (n !== 0) begin
      failures++;
      $display("FAIL abort spurious valid at edge %0d, expected none", n);
    end
    asserts++;
    if (bpm_o !== 8'd0) begin
      failures++;
      $display("FAIL abort bpm: got %0d, expected 0", bpm_o);
    end
    run_div(24'd750, 8'd80, "per750_after_reset");
  endtask

  // Strobe on the IDLE cycle immediately after DONE must be accepted.
  task automatic test_accept_after_done();
    int n;
    strobe(24'd500);
    wait_valid(40, n);
    asserts++;
    if (n !== LAT || bpm_o !== 8'd120) begin
      failures++;
      $display("FAIL chain first: edge=%0d bpm=%0d, expected edge=%0d bpm=120", n, bpm_o, LAT);
    end
    strobe(24'd240);
    asserts++;
    if (bpm_valid !== 1'b0) begin
      failures++;
      $display("FAIL chain pulse width: valid=%b, expected 0", bpm_valid);
    end
    wait_valid(40, n);
    asserts++;
    if (n !== LAT || bpm_o !== 8'd250) begin
      failures++;
      $display("FAIL chain second: edge=%0d bpm=%0d, expected edge=%0d bpm=250", n, bpm_o, LAT);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_saturation();
    test_slow();
    test_back_to_back();
    test_reset_abort();
    test_accept_after_done();
    asserts++;
    if (pulses_seen == 0) begin
      failures++;
      $display("FAIL cover bpm_valid: seen %0d pulses, expected >0", pulses_seen);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
